video_route_controller: RTL

Sequences the video-path control outputs (video_oe_x, int_ext_x, hd_sd_x, rgb_comp_x) between the monitor-interface requests and the back-panel button overrides. Any routing change runs a break-before-make sequence: blank the video output, switch the routing, wait for the path to settle, then re-enable. The block sits between monitor_interface, the filtered button pulses and the video_format_detector on one side, and the board video-switch pins on the other.

---
 rtl/video_route_controller.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/video_route_controller.sv
// video_route_controller
//
// Sequences the board video-switch pins between monitor-interface requests and
// back-panel button overrides. Every routing change is break-before-make:
// blank the output, switch the routing, let the path settle, then re-enable.
//
// Optional feature macro: FORMAT_RESYNC_EN
//   When defined, a change of video_format seen in IDLE also runs a full
//   blank/apply/settle/enable sequence, and the stored format register is
//   updated at APPLY. When undefined, video_format is ignored.
//
// Parameters:
//   BLANK_CYCLES   cycles spent blanked before routing switches (>= 1, < 2^24)
//   SETTLE_CYCLES  cycles after switching before re-enable       (>= 1, < 2^24)
//
// Ports:
//   clk_50mhz_in      system clock
//   reset             asynchronous active-high reset
//   host_video_oe_x   requested output enable (active low)
//   host_int_ext_x    requested source select
//   host_hd_sd_x      requested HD/SD select
//   host_rgb_comp_x   requested RGB/component select
//   btn_force_pulse   one-cycle pulse, toggles forced mode
//   btn_src_pulse     one-cycle pulse, toggles forced source
//   video_format      current detected format code
//   video_oe_x        applied output enable (active low)
//   int_ext_x         applied source select
//   hd_sd_x           applied HD/SD select
//   rgb_comp_x        applied RGB/component select
//   forced            forced mode active
//   busy              high whenever a sequence is in progress
//   change_done       one-cycle pulse when a sequence completes

module video_route_controller #(
    parameter int unsigned BLANK_CYCLES  = 50000,
    parameter int unsigned SETTLE_CYCLES = 500000
) (
    input  logic       clk_50mhz_in,
    input  logic       reset,
    input  logic       host_video_oe_x,
    input  logic       host_int_ext_x,
    input  logic       host_hd_sd_x,
    input  logic       host_rgb_comp_x,
    input  logic       btn_force_pulse,
    input  logic       btn_src_pulse,
    input  logic [7:0] video_format,
    output logic       video_oe_x,
    output logic       int_ext_x,
    output logic       hd_sd_x,
    output logic       rgb_comp_x,
    output logic       forced,
    output logic       busy,
    output logic       change_done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] BLANK  = 3'd1;
    localparam logic [2:0] APPLY  = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] ENABLE = 3'd4;

    // The counter is loaded on state entry and the state is left on the cycle
    // it reads zero, so a load of N-1 gives exactly N cycles in the state.
    localparam logic [23:0] BLANK_LOAD  = 24'(BLANK_CYCLES - 1);
    localparam logic [23:0] SETTLE_LOAD = 24'(SETTLE_CYCLES - 1);

    // Routing vectors are packed as {int_ext, hd_sd, rgb_comp}.
    localparam logic [2:0] ROUTE_RESET = 3'b101;

    logic [2:0]  state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        oe_q, oe_d;
    logic [2:0]  route_q, route_d;
    logic        done_q, done_d;
    logic        forced_q;
    logic        forced_src_q;

    logic        tgt_oe;
    logic [2:0]  tgt_route;
    logic        route_diff;
    logic        fmt_diff;

    // Forced mode pins the output enabled and overrides only the source select.
    assign tgt_oe     = forced_q ? 1'b0 : host_video_oe_x;
    assign tgt_route  = {(forced_q ? forced_src_q : host_int_ext_x), host_hd_sd_x, host_rgb_comp_x};
    assign route_diff = (tgt_route != route_q);

`ifdef FORMAT_RESYNC_EN
    logic [7:0] fmt_q, fmt_d;

    assign fmt_diff = (video_format != fmt_q);

    always_ff @(posedge clk_50mhz_in or posedge reset) begin
        if (reset) begin
            fmt_q <= 8'h00;
        end else begin
            fmt_q <= fmt_d;
        end
    end
`else
    logic unused_video_format;

    assign fmt_diff            = 1'b0;
    assign unused_video_format = ^video_format;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oe_d    = oe_q;
        route_d = route_q;
        done_d  = 1'b0;
`ifdef FORMAT_RESYNC_EN
        fmt_d   = fmt_q;
`endif

        case (state_q)
            IDLE: begin
                if (route_diff || fmt_diff) begin
                    state_d = BLANK;
                    cnt_d   = BLANK_LOAD;
                    oe_d    = 1'b1;
                end else begin
                    // Enable-only changes need no break-before-make.
                    oe_d = tgt_oe;
                end
            end
            BLANK: begin
                oe_d = 1'b1;
                if (cnt_q == 24'd0) begin
                    state_d = APPLY;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            APPLY: begin
                oe_d    = 1'b1;
                route_d = tgt_route;
`ifdef FORMAT_RESYNC_EN
                fmt_d   = video_format;
`endif
                state_d = SETTLE;
                cnt_d   = SETTLE_LOAD;
            end
            SETTLE: begin
                oe_d = 1'b1;
                if (cnt_q == 24'd0) begin
                    state_d = ENABLE;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            ENABLE: begin
                done_d = 1'b1;
                if (route_diff) begin
                    // Request moved after APPLY: go straight round again and
                    // keep the output blanked between the two sequences.
                    state_d = BLANK;
                    cnt_d   = BLANK_LOAD;
                    oe_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                    oe_d    = tgt_oe;
                end
            end
            default: begin
                state_d = IDLE;
                oe_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_50mhz_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 24'd0;
            oe_q    <= 1'b1;
            route_q <= ROUTE_RESET;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oe_q    <= oe_d;
            route_q <= route_d;
            done_q  <= done_d;
        end
    end

    // Button toggles are honoured in every state, including mid-sequence.
    always_ff @(posedge clk_50mhz_in or posedge reset) begin
        if (reset) begin
            forced_q     <= 1'b0;
            forced_src_q <= 1'b1;
        end else begin
            forced_q     <= forced_q ^ btn_force_pulse;
            forced_src_q <= forced_src_q ^ btn_src_pulse;
        end
    end

    assign video_oe_x  = oe_q;
    assign int_ext_x   = route_q[2];
    assign hd_sd_x     = route_q[1];
    assign rgb_comp_x  = route_q[0];
    assign forced      = forced_q;
    assign busy        = (state_q != IDLE);
    assign change_done = done_q;

endmodule
